truth_table_checker: RTL and testbench

//  Self-checking response end for the gate stimulus flow. It walks every input

---
 rtl/tt_check_pkg.sv | 21 ++
 rtl/truth_table_checker_settle_timer.sv | 27 ++
 rtl/truth_table_checker.sv | 109 ++++++++++
 tb/tb_truth_table_checker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_check_pkg.sv
// Shared definitions for the truth-table checker: FSM state encoding and
// a constant-width helper.
package tt_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tt_state_e;

  // Bits needed to hold values 0..n-1 (0 for n<=1).
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Down-counter that sets how long each vector is held; load wins over
// decrement, and zero marks the compare cycle.
module settle_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - WIDTH'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Walks every input vector of a small combinational DUT, samples its output
// after a settle time and scores it against the expected truth table.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int                  N_IN   = 2,
  parameter logic [2**N_IN-1:0]  TRUTH  = 4'b0111,
  parameter int                  SETTLE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            y_obs,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam int CNT_W = (clog2(SETTLE) < 1) ? 1 : clog2(SETTLE);
  localparam int ERR_W = N_IN + 1;

  tt_state_e          state_q, state_d;
  logic               start_run, compare, last_vec, mismatch;
  logic               timer_load, timer_dec, timer_zero;
  logic [CNT_W-1:0]   timer_val;

  settle_timer #(.WIDTH(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (CNT_W'(SETTLE - 1)),
    .dec      (timer_dec),
    .value    (timer_val),
    .zero     (timer_zero)
  );

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; a missing default would infer a latch.
  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    compare   = 1'b0;
    last_vec  = &stim;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_run = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (timer_zero) begin
          compare = 1'b1;
          if (last_vec) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    mismatch   = compare && (y_obs != TRUTH[stim]);
    timer_load = start_run || (compare && !last_vec);
    timer_dec  = (state_q == ST_RUN) && !timer_zero;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      state_q <= state_d;
      if (start_run) begin
        stim           <= '0;
        busy           <= 1'b1;
        done           <= 1'b0;
        err_count      <= '0;
        fail_valid     <= 1'b0;
        first_fail_idx <= '0;
      end else if (compare) begin
        if (mismatch) begin
          err_count <= err_count + ERR_W'(1);
          if (!fail_valid) begin
            fail_valid     <= 1'b1;
            first_fail_idx <= stim;
          end
        end
        // The final vector stays on stim once the run completes.
        if (last_vec) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          stim <= stim + N_IN'(1);
        end
      end
    end
  end

  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: table-driven response patterns, hand-written
// restart/reset sequences and randomized patterns scored by a counting model.
module tb_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Default instance: 2-input NAND, SETTLE=4
  logic       start2;
  logic [3:0] pat2;
  logic       y2;
  logic [1:0] stim2, ffi2;
  logic [2:0] err2;
  logic       busy2, done2, pass2, fv2;

  // 3-input NAND, SETTLE=1
  logic       start3;
  logic [7:0] pat3;
  logic       y3;
  logic [2:0] stim3, ffi3;
  logic [3:0] err3;
  logic       busy3, done3, pass3, fv3;

  // The emulated DUT answers pattern[stim] for each applied vector.
  assign y2 = pat2[stim2];
  assign y3 = pat3[stim3];

  truth_table_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start2), .stim(stim2), .y_obs(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .first_fail_idx(ffi2)
  );

  truth_table_checker #(.N_IN(3), .TRUTH(8'h7F), .SETTLE(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .stim(stim3), .y_obs(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .first_fail_idx(ffi3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Instance selector so one run task serves both checkers.
  int sel = 0;
  int cur_stim, cur_err, cur_ffi;
  logic cur_busy, cur_done, cur_pass, cur_fv;
  always_comb begin
    cur_stim = (sel != 0) ? int'(stim3) : int'(stim2);
    cur_err  = (sel != 0) ? int'(err3)  : int'(err2);
    cur_ffi  = (sel != 0) ? int'(ffi3)  : int'(ffi2);
    cur_busy = (sel != 0) ? busy3 : busy2;
    cur_done = (sel != 0) ? done3 : done2;
    cur_pass = (sel != 0) ? pass3 : pass2;
    cur_fv   = (sel != 0) ? fv3   : fv2;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input bit v);
    if (sel != 0) start3 = v; else start2 = v;
  endtask

  // Expected results from plain counting over the vector list.
  function automatic void ref_model(input logic [7:0] truth, input logic [7:0] obs,
                                    input int nvec, output int err, output int first);
    err   = 0;
    first = -1;
    for (int i = 0; i < nvec; i++) begin
      if (truth[i] != obs[i]) begin
        err++;
        if (first < 0) first = i;
      end
    end
  endfunction

  // Pulse start, then follow the run edge by edge until done or budget.
  task automatic do_run(input int settle, input int nvec, input int repulse_at,
                        output int cycles, output bit trace_ok);
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0);
    trace_ok = (cur_stim == 0) && cur_busy && !cur_done && (cur_err == 0) && !cur_fv;
    cycles = 0;
    while (!cur_done && cycles < 200) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (cycles == repulse_at)     set_start(1'b1);
      if (cycles == repulse_at + 1) set_start(1'b0);
      if (!cur_done) begin
        if (cur_stim != cycles / settle || !cur_busy) trace_ok = 1'b0;
      end else begin
        if (cur_stim != nvec - 1 || cur_busy) trace_ok = 1'b0;
      end
    end
  endtask

  task automatic check_results(input string tag, input int exp_err, input int exp_first);
    check({tag, "_err_count"}, cur_err, exp_err);
    check({tag, "_fail_valid"}, int'(cur_fv), (exp_err != 0) ? 1 : 0);
    if (exp_err != 0) check({tag, "_first_fail_idx"}, cur_ffi, exp_first);
    check({tag, "_pass"}, int'(cur_pass), (exp_err == 0) ? 1 : 0);
    check({tag, "_done"}, int'(cur_done), 1);
  endtask

  typedef struct {
    string      name;
    logic [3:0] pat;
    int         exp_err;
    int         exp_first;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int cycles, e, f;
    bit ok;

    tbl[0] = '{name: "golden",   pat: 4'b0111, exp_err: 0, exp_first: 0};
    tbl[1] = '{name: "tied1",    pat: 4'b1111, exp_err: 1, exp_first: 3};
    tbl[2] = '{name: "tied0",    pat: 4'b0000, exp_err: 3, exp_first: 0};
    tbl[3] = '{name: "inverted", pat: 4'b1000, exp_err: 4, exp_first: 0};
    tbl[4] = '{name: "v0_bad",   pat: 4'b0110, exp_err: 1, exp_first: 0};
    tbl[5] = '{name: "v1_bad",   pat: 4'b0101, exp_err: 1, exp_first: 1};

    rst_n  = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    pat2   = 4'b0111;
    pat3   = 8'h7F;
    #1;
    check("rst_stim", int'(stim2), 0);
    check("rst_busy", int'(busy2), 0);
    check("rst_done", int'(done2), 0);
    check("rst_pass", int'(pass2), 0);
    check("rst_err",  int'(err2),  0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    sel = 0;
    for (int i = 0; i < 6; i++) begin
      pat2 = tbl[i].pat;
      do_run(4, 4, -10, cycles, ok);
      check({tbl[i].name, "_stim_trace"}, int'(ok), 1);
      check({tbl[i].name, "_done_cycle"}, cycles, 16);
      check_results(tbl[i].name, tbl[i].exp_err, tbl[i].exp_first);
    end

    // Results hold in DONE without a new start
    repeat (5) @(negedge clk);
    check("hold_err", int'(err2), 1);
    check("hold_done", int'(done2), 1);

    // start during RUN is ignored
    pat2 = 4'b0111;
    do_run(4, 4, 5, cycles, ok);
    check("repulse_trace", int'(ok), 1);
    check("repulse_done_cycle", cycles, 16);
    check_results("repulse", 0, 0);

    // Asynchronous reset in the middle of a run that already has an error
    pat2 = 4'b0000;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_reset_err", int'(err2), 1);
    rst_n = 1'b0;
    #1;
    check("areset_stim", int'(stim2), 0);
    check("areset_busy", int'(busy2), 0);
    check("areset_done", int'(done2), 0);
    check("areset_err",  int'(err2),  0);
    check("areset_fv",   int'(fv2),   0);
    check("areset_ffi",  int'(ffi2),  0);
    check("areset_pass", int'(pass2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset_busy", int'(busy2), 0);
    pat2 = 4'b0111;
    do_run(4, 4, -10, cycles, ok);
    check("post_reset_trace", int'(ok), 1);
    check("post_reset_done_cycle", cycles, 16);
    check_results("post_reset", 0, 0);

    // Randomized patterns on the 2-input checker
    for (int r = 0; r < 15; r++) begin
      pat2 = 4'($urandom_range(0, 15));
      ref_model(8'h07, {4'b0, pat2}, 4, e, f);
      do_run(4, 4, -10, cycles, ok);
      check("rand2_done_cycle", cycles, 16);
      check_results("rand2", e, f);
    end

    // 3-input NAND, one cycle per vector
    sel  = 1;
    pat3 = 8'h7F;
    do_run(1, 8, -10, cycles, ok);
    check("n3_trace", int'(ok), 1);
    check("n3_done_cycle", cycles, 8);
    check_results("n3_golden", 0, 0);

    pat3 = 8'h00;
    do_run(1, 8, -10, cycles, ok);
    check_results("n3_tied0", 7, 0);

    // New start from DONE clears results on the reload edge
    pat3 = 8'h7F;
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    check("restart_done", int'(done3), 0);
    check("restart_err",  int'(err3),  0);
    check("restart_fv",   int'(fv3),   0);
    check("restart_stim", int'(stim3), 0);
    check("restart_busy", int'(busy3), 1);
    @(negedge clk);
    start3 = 1'b0;
    cycles = 0;
    while (!done3 && cycles < 50) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("restart_done_cycle", cycles, 8);
    check_results("restart", 0, 0);

    for (int r = 0; r < 15; r++) begin
      pat3 = 8'($urandom_range(0, 255));
      ref_model(8'h7F, pat3, 8, e, f);
      do_run(1, 8, -10, cycles, ok);
      check("rand3_done_cycle", cycles, 8);
      check_results("rand3", e, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
